// File: rtl/solver_sequencer.sv
// solver_sequencer: per-pixel escape-time controller. Walks the limb-serial
// z-series datapath through an optional abs pass (burning ship) and the
// iterate pass, waits out pipeline flushes, compares against the iteration
// limit and hands the result back over a valid/ready handshake.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   cfg_wr_en, cfg_num_limbs,
//   cfg_iter_lim, cfg_mode       configuration, latched in IDLE only
//   c_wr_en -> cre/cim_wr_en     c load strobe, passed through only in IDLE
//   start, abort                 begin / cancel a solve
//   zre_sign, zim_sign, diverged datapath status, sampled in CHECK
//   op_abs, limb_ind, zre_ind,
//   zim_ind, flip, first_partial,
//   top_limb, zre_neg, zim_neg,
//   z_wr_en                      datapath sequencing controls
//   busy                         solve in progress
//   res_valid, res_ready,
//   res_count, res_escaped       result handshake
module solver_sequencer #(
  parameter int unsigned LIMB_INDEX_BITS = 6,
  parameter int unsigned ITER_BITS       = 16,
  parameter int unsigned FLUSH_WAIT      = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_wr_en,
  input  logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs,
  input  logic [ITER_BITS-1:0]       cfg_iter_lim,
  input  logic                       cfg_mode,
  input  logic                       c_wr_en,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       zre_sign,
  input  logic                       zim_sign,
  input  logic                       diverged,
  output logic                       cre_wr_en,
  output logic                       cim_wr_en,
  output logic                       op_abs,
  output logic [LIMB_INDEX_BITS-1:0] limb_ind,
  output logic [LIMB_INDEX_BITS-1:0] zre_ind,
  output logic [LIMB_INDEX_BITS-1:0] zim_ind,
  output logic                       flip,
  output logic                       first_partial,
  output logic                       top_limb,
  output logic                       zre_neg,
  output logic                       zim_neg,
  output logic                       z_wr_en,
  output logic                       busy,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ITER_BITS-1:0]       res_count,
  output logic                       res_escaped
);

  localparam int unsigned FLUSH_BITS = (FLUSH_WAIT < 1) ? 1 : $clog2(FLUSH_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ABS, S_ABS_FLUSH, S_ITER, S_ITER_FLUSH, S_CHECK, S_DONE
  } state_t;

  state_t                     state;
  logic [LIMB_INDEX_BITS-1:0] n_q;
  logic [ITER_BITS-1:0]       lim_q;
  logic                       mode_q;
  logic [LIMB_INDEX_BITS-1:0] limb_q;
  logic [LIMB_INDEX_BITS-1:0] part_q;
  logic                       flip_q;
  logic [FLUSH_BITS-1:0]      flush_q;
  logic [ITER_BITS-1:0]       count_q;

  logic [LIMB_INDEX_BITS-1:0] n_top;
  logic [LIMB_INDEX_BITS-1:0] half_l;
  logic [LIMB_INDEX_BITS-1:0] diff_l;
  logic                       last_part;
  logic                       flush_end;

  assign n_top     = n_q - LIMB_INDEX_BITS'(1);
  assign half_l    = limb_q >> 1;
  assign diff_l    = limb_q - part_q;
  assign last_part = (part_q == half_l);
  assign flush_end = (flush_q == FLUSH_BITS'(FLUSH_WAIT));

  // Output decode from registered state and counters.
  always_comb begin
    op_abs        = 1'b0;
    zre_ind       = '0;
    zim_ind       = '0;
    flip          = 1'b0;
    first_partial = 1'b0;
    z_wr_en       = 1'b0;
    limb_ind      = limb_q;
    top_limb      = (limb_q == n_top);
    busy          = (state != S_IDLE);
    res_valid     = (state == S_DONE);
    cre_wr_en     = c_wr_en & (state == S_IDLE);
    cim_wr_en     = c_wr_en & (state == S_IDLE);
    case (state)
      S_ABS: begin
        op_abs  = 1'b1;
        z_wr_en = 1'b1;
        zre_ind = limb_q;
        zim_ind = limb_q;
      end
      S_ITER: begin
        flip          = flip_q;
        first_partial = (part_q == '0);
        // flip swaps which operand takes the high-side limb of the partial pair
        zre_ind       = flip_q ? part_q : diff_l;
        zim_ind       = flip_q ? diff_l : part_q;
        z_wr_en       = flip_q & last_part;
      end
      default: ;
    endcase
  end

  // Sequencer state, counters, latched config and result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      n_q         <= LIMB_INDEX_BITS'(1);
      lim_q       <= '0;
      mode_q      <= 1'b0;
      limb_q      <= '0;
      part_q      <= '0;
      flip_q      <= 1'b0;
      flush_q     <= '0;
      count_q     <= '0;
      zre_neg     <= 1'b0;
      zim_neg     <= 1'b0;
      res_count   <= '0;
      res_escaped <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      state   <= S_IDLE;
      part_q  <= '0;
      flip_q  <= 1'b0;
      flush_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_wr_en) begin
            n_q    <= cfg_num_limbs;
            lim_q  <= cfg_iter_lim;
            mode_q <= cfg_mode;
          end else if (start && (n_q != '0)) begin
            count_q <= '0;
            zre_neg <= 1'b0;
            zim_neg <= 1'b0;
            limb_q  <= n_top;
            part_q  <= '0;
            flip_q  <= 1'b0;
            state   <= mode_q ? S_ABS : S_ITER;
          end
        end
        S_ABS: begin
          if (limb_q == '0) begin
            limb_q <= n_top;
            state  <= S_ABS_FLUSH;
          end else begin
            limb_q <= limb_q - LIMB_INDEX_BITS'(1);
          end
        end
        S_ABS_FLUSH: begin
          if (flush_end) begin
            flush_q <= '0;
            state   <= S_ITER;
          end else begin
            flush_q <= flush_q + FLUSH_BITS'(1);
          end
        end
        S_ITER: begin
          if (!flip_q) begin
            flip_q <= 1'b1;
          end else begin
            flip_q <= 1'b0;
            if (last_part) begin
              part_q <= '0;
              if (limb_q == '0) state <= S_ITER_FLUSH;
              else              limb_q <= limb_q - LIMB_INDEX_BITS'(1);
            end else begin
              part_q <= part_q + LIMB_INDEX_BITS'(1);
            end
          end
        end
        S_ITER_FLUSH: begin
          if (flush_end) begin
            flush_q <= '0;
            state   <= S_CHECK;
          end else begin
            flush_q <= flush_q + FLUSH_BITS'(1);
          end
        end
        S_CHECK: begin
          zre_neg <= zre_sign;
          zim_neg <= zim_sign;
          if (diverged) begin
            res_count   <= count_q;
            res_escaped <= 1'b1;
            state       <= S_DONE;
          end else if (count_q == lim_q) begin
            res_count   <= lim_q;
            res_escaped <= 1'b0;
            state       <= S_DONE;
          end else begin
            count_q <= count_q + ITER_BITS'(1);
            limb_q  <= n_top;
            state   <= mode_q ? S_ABS : S_ITER;
          end
        end
        S_DONE: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_solver_sequencer.sv
// Bench for solver_sequencer: a per-cycle expected trace is built from the
// solve rules (nested limb/partial loops, flush lengths, check outcome) and
// every busy cycle of the DUT is compared against it.
module tb_solver_sequencer;
  localparam int LB = 6;
  localparam int IB = 16;
  localparam int FW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_wr_en = 1'b0;
  logic [LB-1:0] cfg_num_limbs = '0;
  logic [IB-1:0] cfg_iter_lim = '0;
  logic          cfg_mode = 1'b0;
  logic          c_wr_en = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          zre_sign = 1'b0, zim_sign = 1'b0, diverged = 1'b0;
  logic          res_ready = 1'b0;
  logic          cre_wr_en, cim_wr_en, op_abs, flip, first_partial, top_limb;
  logic          zre_neg, zim_neg, z_wr_en, busy, res_valid, res_escaped;
  logic [LB-1:0] limb_ind, zre_ind, zim_ind;
  logic [IB-1:0] res_count;

  always #5 clock = ~clock;

  solver_sequencer #(.LIMB_INDEX_BITS(LB), .ITER_BITS(IB), .FLUSH_WAIT(FW)) dut (
    .clock(clock), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_num_limbs(cfg_num_limbs),
    .cfg_iter_lim(cfg_iter_lim), .cfg_mode(cfg_mode), .c_wr_en(c_wr_en), .start(start),
    .abort(abort), .zre_sign(zre_sign), .zim_sign(zim_sign), .diverged(diverged),
    .cre_wr_en(cre_wr_en), .cim_wr_en(cim_wr_en), .op_abs(op_abs), .limb_ind(limb_ind),
    .zre_ind(zre_ind), .zim_ind(zim_ind), .flip(flip), .first_partial(first_partial),
    .top_limb(top_limb), .zre_neg(zre_neg), .zim_neg(zim_neg), .z_wr_en(z_wr_en),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count),
    .res_escaped(res_escaped));

  typedef enum int {K_ABS, K_AF, K_IT, K_IF, K_CHK, K_DONE} kind_t;
  typedef struct {
    kind_t kind;
    bit op_abs, flip, first, z_wr, top, valid, esc, zn, in;
    int limb, zre, zim, cnt;
    bit d_div, d_zs, d_is;
  } cyc_t;

  int   errors = 0;
  int   checks = 0;
  int   cur_ix = 0;
  int   m_n = 1, m_lim = 0, m_mode = 0;
  bit   m_zn = 1'b0, m_in = 1'b0;
  cyc_t tr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cur_ix, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic cyc_t blank(kind_t k, bit rnd);
    cyc_t e;
    e.kind = k; e.op_abs = 0; e.flip = 0; e.first = 0; e.z_wr = 0; e.top = 0;
    e.valid = 0; e.esc = 0; e.zn = m_zn; e.in = m_in;
    e.limb = 0; e.zre = 0; e.zim = 0; e.cnt = 0;
    e.d_div = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    e.d_zs = 1'($urandom_range(0, 1));
    e.d_is = 1'($urandom_range(0, 1));
    return e;
  endfunction

  // Expected trace for one solve, cycle 1 onwards; div_at < 0 means random divergence.
  task automatic build(input int div_at);
    cyc_t e;
    bit rnd = (div_at < 0);
    tr.delete();
    m_zn = 0; m_in = 0;
    for (int it = 0; it <= m_lim; it++) begin
      if (m_mode != 0) begin
        for (int l = m_n - 1; l >= 0; l--) begin
          e = blank(K_ABS, rnd);
          e.op_abs = 1; e.z_wr = 1; e.limb = l; e.zre = l; e.zim = l; e.top = (l == m_n - 1);
          tr.push_back(e);
        end
        for (int f = 0; f <= FW; f++) tr.push_back(blank(K_AF, rnd));
      end
      for (int l = m_n - 1; l >= 0; l--)
        for (int p = 0; p <= l / 2; p++)
          for (int f = 0; f < 2; f++) begin
            e = blank(K_IT, rnd);
            e.flip = (f == 1); e.first = (p == 0); e.limb = l; e.top = (l == m_n - 1);
            e.zre = (f == 1) ? p : l - p;
            e.zim = (f == 1) ? l - p : p;
            e.z_wr = (f == 1) && (p == l / 2);
            tr.push_back(e);
          end
      for (int f = 0; f <= FW; f++) tr.push_back(blank(K_IF, rnd));
      e = blank(K_CHK, rnd);
      e.d_div = rnd ? ($urandom_range(0, 3) == 0) : (it == div_at);
      tr.push_back(e);
      m_zn = e.d_zs; m_in = e.d_is;
      if (e.d_div || it == m_lim) begin
        e = blank(K_DONE, 0);
        e.valid = 1; e.cnt = it; e.esc = tr[tr.size()-1].d_div;
        tr.push_back(e);
        break;
      end
    end
  endtask

  task automatic compare(input cyc_t e);
    chk("busy", busy, 1);
    chk("op_abs", op_abs, e.op_abs);
    chk("z_wr_en", z_wr_en, e.z_wr);
    chk("flip", flip, e.flip);
    chk("first_partial", first_partial, e.first);
    chk("res_valid", res_valid, e.valid);
    chk("zre_neg", zre_neg, e.zn);
    chk("zim_neg", zim_neg, e.in);
    chk("cre_blocked", cre_wr_en, 0);
    chk("cim_blocked", cim_wr_en, 0);
    if (e.kind == K_ABS || e.kind == K_IT) begin
      chk("limb_ind", limb_ind, e.limb);
      chk("zre_ind", zre_ind, e.zre);
      chk("zim_ind", zim_ind, e.zim);
      chk("top_limb", top_limb, e.top);
    end
    if (e.kind == K_DONE) begin
      chk("res_count", res_count, e.cnt);
      chk("res_escaped", res_escaped, e.esc);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, res_valid, 0);
    chk({tag, "_z_wr"}, z_wr_en, 0);
    chk({tag, "_cre"}, cre_wr_en, c_wr_en);
  endtask

  task automatic check_reset();
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_limb", limb_ind, 0);
    chk("rst_top", top_limb, 1);
    chk("rst_zre", zre_ind, 0);
    chk("rst_zim", zim_ind, 0);
    chk("rst_ctl", {op_abs, flip, first_partial, z_wr_en, zre_neg, zim_neg, cre_wr_en, cim_wr_en}, 0);
    chk("rst_res", {res_count, res_escaped}, 0);
  endtask

  task automatic run_txn(input bit do_cfg, input int n, input int lim, input int mode,
                         input int div_at, input int hold, input bit do_abort,
                         input kind_t abort_k, output int done_cyc);
    int last;
    if (do_cfg) begin
      cfg_wr_en = 1; cfg_num_limbs = LB'(n); cfg_iter_lim = IB'(lim); cfg_mode = 1'(mode);
      tick();
      cfg_wr_en = 0;
      m_n = n; m_lim = lim; m_mode = mode;
    end
    build(div_at);
    done_cyc = tr.size();
    last = tr.size() - 1;
    start = 1;
    tick();
    for (int k = 0; k <= last; k++) begin
      cur_ix = k + 1;
      compare(tr[k]);
      diverged = tr[k].d_div; zre_sign = tr[k].d_zs; zim_sign = tr[k].d_is;
      c_wr_en = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1));
      res_ready = (tr[k].kind == K_DONE) ? 1'b0 : 1'($urandom_range(0, 1));
      if (do_abort && tr[k].kind == abort_k) begin
        abort = 1; start = 0;
        tick();
        abort = 0;
        check_idle("abort");
        done_cyc = -1;
        return;
      end
      if (k != last) tick();
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      cur_ix++;
      compare(tr[last]);
      start = 1'($urandom_range(0, 1));
      c_wr_en = 1'($urandom_range(0, 1));
    end
    res_ready = 1; start = 0;
    tick();
    res_ready = 0;
    check_idle("handshake");
  endtask

  initial begin
    int dc;
    int iter_cnt;
    tick(); tick();
    reset = 0;
    tick();
    check_reset();

    c_wr_en = 1;
    #1;
    chk("c_mirror_re", cre_wr_en, 1);
    chk("c_mirror_im", cim_wr_en, 1);
    c_wr_en = 0;

    // N=2 Mandelbrot, limit 0
    run_txn(1, 2, 0, 0, 99, 0, 0, K_ABS, dc);
    chk("lat_mandel", dc, 11);
    chk("pin_t1_zre", tr[0].zre, 1);
    chk("pin_t2_zim", tr[1].zim, 1);
    chk("pin_t2_zwr", tr[1].z_wr, 1);
    chk("pin_t3_zwr", tr[2].z_wr, 0);

    // N=2 burning ship, limit 0
    run_txn(1, 2, 0, 1, 99, 0, 0, K_ABS, dc);
    chk("lat_ship", dc, 18);
    chk("pin_abs_l0", tr[1].limb, 0);
    chk("pin_iter_start", tr[7].kind == K_IT && tr[6].kind == K_AF, 1);

    // N=4 limit 5, divergence in third check, long back-pressure
    run_txn(1, 4, 5, 0, 2, 10, 0, K_ABS, dc);
    chk("pin_div_cnt", tr[tr.size()-1].cnt, 2);
    chk("pin_div_esc", tr[tr.size()-1].esc, 1);
    iter_cnt = 0;
    foreach (tr[i]) if (tr[i].kind == K_IT) iter_cnt++;
    chk("pin_iter_len", iter_cnt, 36);

    // abort in ITER_FLUSH, then restart with kept config
    run_txn(1, 3, 4, 1, 99, 0, 1, K_IF, dc);
    tick();
    check_idle("post_abort");
    run_txn(0, 0, 0, 0, 99, 0, 0, K_ABS, dc);
    chk("lat_reuse_cfg", dc, 111);

    // cfg_wr_en together with start
    cfg_wr_en = 1; cfg_num_limbs = 3; cfg_iter_lim = 1; cfg_mode = 0; start = 1;
    tick();
    chk("cfg_start_ignored", busy, 0);
    cfg_wr_en = 0; start = 0;
    m_n = 3; m_lim = 1; m_mode = 0;
    run_txn(0, 0, 0, 0, 99, 0, 0, K_ABS, dc);
    chk("lat_new_cfg", dc, 29);

    // N = 0 never starts
    cfg_wr_en = 1; cfg_num_limbs = 0;
    tick();
    cfg_wr_en = 0; start = 1;
    tick(); tick();
    chk("n0_idle", busy, 0);
    start = 0;

    // reset mid-solve returns config to defaults
    run_txn(1, 3, 3, 1, 99, 0, 1, K_IT, dc);
    cfg_wr_en = 1; cfg_num_limbs = 3; cfg_iter_lim = 3; cfg_mode = 1;
    tick();
    cfg_wr_en = 0; start = 1;
    tick();
    start = 0;
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0; c_wr_en = 0;
    #1;
    check_reset();
    m_n = 1; m_lim = 0; m_mode = 0;
    run_txn(0, 0, 0, 0, 99, 0, 0, K_ABS, dc);
    chk("lat_after_reset", dc, 9);

    // randomized solves
    for (int t = 0; t < 30; t++) begin
      bit ab = ($urandom_range(0, 4) == 0);
      kind_t ak = kind_t'($urandom_range(0, 5));
      int md = $urandom_range(0, 1);
      if (ak == K_ABS || ak == K_AF) md = 1;
      run_txn(1, $urandom_range(1, 7), $urandom_range(0, 6), md, -1,
              $urandom_range(0, 3), ab, ak, dc);
      if ($urandom_range(0, 1) == 1) begin
        c_wr_en = 0;
        tick();
        check_idle("gap");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
